// File: rtl/ring_noc_pkg.sv
// Shared ring NoC definitions: packet geometry, header field positions and
// the NIC processor-side register map.
package ring_noc_pkg;

  localparam int unsigned PACKET_SIZE = 64;
  localparam int unsigned VC_BIT      = 63;
  localparam int unsigned DIR_BIT     = 62;
  localparam int unsigned HOP_HI      = 55;
  localparam int unsigned HOP_LO      = 48;

  typedef enum logic [1:0] {
    ADDR_IN_BUF     = 2'b00,
    ADDR_IN_STATUS  = 2'b01,
    ADDR_OUT_BUF    = 2'b10,
    ADDR_OUT_STATUS = 2'b11
  } nic_addr_e;

endpackage

// File: rtl/nic_channel_buffer.sv
// One-entry packet register with a full flag, loaded and cleared by
// single-cycle strobes.
module nic_channel_buffer #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             full
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q    <= '0;
      full <= 1'b0;
    end else if (load) begin
      q    <= d;
      full <= 1'b1;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/ring_nic.sv
// Ring NIC: single-entry input/output channels between a PE register map and
// the router PE port, with injection gated by router VC polarity.
module ring_nic
  import ring_noc_pkg::*;
#(
  parameter int unsigned PACKET_SIZE = ring_noc_pkg::PACKET_SIZE,
  parameter int unsigned VC_BIT      = ring_noc_pkg::VC_BIT,
  parameter int unsigned ADDR_WIDTH  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [PACKET_SIZE-1:0] d_in,
  output logic [PACKET_SIZE-1:0] d_out,
  input  logic                   nicEn,
  input  logic                   nicWrEn,
  input  logic                   net_si,
  output logic                   net_ri,
  input  logic [PACKET_SIZE-1:0] net_di,
  output logic                   net_so,
  input  logic                   net_ro,
  output logic [PACKET_SIZE-1:0] net_do,
  input  logic                   net_polarity
);

  logic                   in_full, out_full;
  logic [PACKET_SIZE-1:0] in_buf, out_buf;
  logic                   rd, wr, in_load, in_clear, out_load;

  always_comb begin
    rd       = nicEn & ~nicWrEn;
    wr       = nicEn & nicWrEn;
    net_ri   = ~in_full;
    in_load  = net_si & ~in_full;
    in_clear = rd & (addr == ADDR_IN_BUF) & in_full;
    out_load = wr & (addr == ADDR_OUT_BUF) & ~out_full;
    net_so   = out_full & net_ro & (out_buf[VC_BIT] == net_polarity);
    net_do   = out_buf;
  end

  nic_channel_buffer #(.WIDTH(PACKET_SIZE)) u_in_chan (
    .clk   (clk),
    .reset (reset),
    .load  (in_load),
    .clear (in_clear),
    .d     (net_di),
    .q     (in_buf),
    .full  (in_full)
  );

  // A write that coincides with transmission sees out_full=1 and is dropped.
  nic_channel_buffer #(.WIDTH(PACKET_SIZE)) u_out_chan (
    .clk   (clk),
    .reset (reset),
    .load  (out_load),
    .clear (net_so),
    .d     (d_in),
    .q     (out_buf),
    .full  (out_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      d_out <= '0;
    end else if (rd) begin
      case (addr)
        ADDR_IN_BUF:     d_out <= in_buf;
        ADDR_IN_STATUS:  d_out <= PACKET_SIZE'(in_full);
        ADDR_OUT_STATUS: d_out <= PACKET_SIZE'(out_full);
        default:         d_out <= d_out;
      endcase
    end
  end

endmodule
